branch_resolve_ctrl: RTL and testbench

//  Sequences early (ID-stage) resolution of BEQ/BNE. Holds the branch in ID while its operands are still in flight.

---
 rtl/branch_pkg.sv | 11 +
 rtl/branch_eq_cmp.sv | 12 +
 rtl/branch_resolve_ctrl.sv | 124 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared opcodes and FSM state encoding for early branch resolution.
package branch_pkg;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_BNE = 6'b000101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    REDIRECT = 2'd2
  } brc_state_t;
endpackage

// File: rtl/branch_eq_cmp.sv
// Purpose: full-width operand equality for ID-stage branch resolution.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module branch_eq_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              eq
);
  assign eq = (a == b);
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Purpose: resolves BEQ/BNE in ID, stalls on in-flight operands, redirects PC on taken.
// Latency: redirect one cycle after resolve; optional counters enabled by BRANCH_STATS_EN.
// Backpressure: stall holds PC and IF/ID while EX ALU or EX/MEM load results are pending.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [DATA_W-1:0] id_data_a,
  input  logic [DATA_W-1:0] id_data_b,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              mem_mem_read,
  input  logic [REG_W-1:0]  mem_rd,
  output logic              stall,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_ifid
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_stall_cyc
`endif
);

  brc_state_t state, state_nxt;

  logic is_beq, is_bne, is_br, eq, taken;
  logic ex_hit, mem_hit, hazard;
  logic stall_c, pc_sel_c, flush_c, resolve;

  branch_eq_cmp #(.DATA_W(DATA_W)) u_eq (
    .a  (id_data_a),
    .b  (id_data_b),
    .eq (eq)
  );

  assign is_beq = id_valid && (id_opcode == OPC_BEQ);
  assign is_bne = id_valid && (id_opcode == OPC_BNE);
  assign is_br  = is_beq || is_bne;
  assign taken  = (is_beq && eq) || (is_bne && !eq);

  // A load in EX also writes its rd, so either flag marks a pending producer.
  assign ex_hit  = (ex_reg_write || ex_mem_read) && (ex_rd != '0) &&
                   ((id_rs == ex_rd) || (id_rt == ex_rd));
  assign mem_hit = mem_mem_read && (mem_rd != '0) &&
                   ((id_rs == mem_rd) || (id_rt == mem_rd));
  assign hazard  = ex_hit || mem_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    pc_sel_c  = 1'b0;
    flush_c   = 1'b0;
    resolve   = 1'b0;
    case (state)
      IDLE, WAIT: begin
        // WAIT resolves like IDLE; a killed or vanished branch simply falls back to IDLE.
        state_nxt = IDLE;
        if (is_br && hazard) begin
          stall_c   = 1'b1;
          state_nxt = WAIT;
        end else if (is_br) begin
          resolve = 1'b1;
          if (taken) state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        pc_sel_c  = 1'b1;
        flush_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gating by rst_n keeps the hazard-driven stall quiet while reset is asserted.
  assign stall      = stall_c  && rst_n;
  assign pc_sel     = pc_sel_c && rst_n;
  assign flush_ifid = flush_c  && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_target <= '0;
    end else if (resolve && taken) begin
      pc_target <= id_target;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches  <= '0;
      stat_taken     <= '0;
      stat_stall_cyc <= '0;
    end else begin
      if (resolve)          stat_branches  <= stat_branches + 1'b1;
      if (resolve && taken) stat_taken     <= stat_taken + 1'b1;
      if (stall_c)          stat_stall_cyc <= stat_stall_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; counter checks appear when BRANCH_STATS_EN is defined.
module tb_branch_resolve_ctrl;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
`ifdef BRANCH_STATS_EN
  localparam int SW = 2;
`else
  localparam int SW = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_data_a, id_data_b, id_target;
  logic        ex_reg_write, ex_mem_read, mem_mem_read;
  logic [4:0]  ex_rd, mem_rd;
  logic        stall, pc_sel, flush_ifid;
  logic [31:0] pc_target;
`ifdef BRANCH_STATS_EN
  logic [SW-1:0] stat_branches, stat_taken, stat_stall_cyc;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .STAT_W(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_data_a    (id_data_a),
    .id_data_b    (id_data_b),
    .id_target    (id_target),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .mem_mem_read (mem_mem_read),
    .mem_rd       (mem_rd),
    .stall        (stall),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .flush_ifid   (flush_ifid)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken),
    .stat_stall_cyc (stat_stall_cyc)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drv_id(input logic v, input logic [5:0] opc, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] tgt);
    id_valid = v; id_opcode = opc; id_rs = rs; id_rt = rt;
    id_data_a = a; id_data_b = b; id_target = tgt;
  endtask

  task automatic drv_haz(input logic exw, input logic exm, input logic [4:0] exrd,
                         input logic mm, input logic [4:0] mrd);
    ex_reg_write = exw; ex_mem_read = exm; ex_rd = exrd;
    mem_mem_read = mm; mem_rd = mrd;
  endtask

  task automatic nop();
    drv_id(1'b1, 6'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    drv_haz(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic s, input logic p, input logic f);
    @(negedge clk);
    chk({tag, ".stall"}, 64'(stall), 64'(s));
    chk({tag, ".pc_sel"}, 64'(pc_sel), 64'(p));
    chk({tag, ".flush"}, 64'(flush_ifid), 64'(f));
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    // Hazardous branch while in reset: stall must remain forced low.
    drv_id(1'b1, BEQ, 5'd3, 5'd4, 32'd1, 32'd1, 32'h100);
    drv_haz(1'b1, 1'b0, 5'd3, 1'b0, 5'd0);
    outs("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.pc_target", 64'(pc_target), 64'h0);
    nop();
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // BEQ taken, no hazard
    drv_id(1'b1, BEQ, 5'd1, 5'd2, 32'h1234, 32'h1234, 32'h400);
    outs("beq_res", 1'b0, 1'b0, 1'b0);
    next_cyc();
    nop();
    outs("beq_redir", 1'b0, 1'b1, 1'b1);
    chk("beq_redir.pc_target", 64'(pc_target), 64'h400);
    next_cyc();
    outs("beq_after", 1'b0, 1'b0, 1'b0);
    chk("beq_after.pc_target_hold", 64'(pc_target), 64'h400);
    next_cyc();

    // BNE not taken
    drv_id(1'b1, BNE, 5'd1, 5'd2, 32'h5, 32'h5, 32'h500);
    outs("bne_nt", 1'b0, 1'b0, 1'b0);
    next_cyc();
    nop();
    outs("bne_nt_next", 1'b0, 1'b0, 1'b0);
    next_cyc();

    // BEQ behind EX load: two stall cycles, then resolve, then redirect
    drv_id(1'b1, BEQ, 5'd3, 5'd4, 32'h77, 32'h77, 32'h800);
    drv_haz(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    outs("ld_stall1", 1'b1, 1'b0, 1'b0);
    next_cyc();
    drv_haz(1'b0, 1'b0, 5'd0, 1'b1, 5'd3);
    outs("ld_stall2", 1'b1, 1'b0, 1'b0);
    next_cyc();
    drv_haz(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    outs("ld_resolve", 1'b0, 1'b0, 1'b0);
    next_cyc();
    nop();
    outs("ld_redir", 1'b0, 1'b1, 1'b1);
    chk("ld_redir.pc_target", 64'(pc_target), 64'h800);
    next_cyc();

    // rt=0 against EX rd=0 never hazards; BEQ with a!=b not taken
    drv_id(1'b1, BEQ, 5'd9, 5'd0, 32'h1, 32'h2, 32'h900);
    drv_haz(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    outs("r0_nohaz", 1'b0, 1'b0, 1'b0);
    next_cyc();
    nop();
    outs("r0_next", 1'b0, 1'b0, 1'b0);
    next_cyc();

    // BNE taken behind EX ALU producer: exactly one stall
    drv_id(1'b1, BNE, 5'd7, 5'd8, 32'h1, 32'h2, 32'hC00);
    drv_haz(1'b1, 1'b0, 5'd7, 1'b0, 5'd0);
    outs("alu_stall", 1'b1, 1'b0, 1'b0);
    next_cyc();
    drv_haz(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    outs("alu_resolve", 1'b0, 1'b0, 1'b0);
    next_cyc();
    nop();
    outs("alu_redir", 1'b0, 1'b1, 1'b1);
    chk("alu_redir.pc_target", 64'(pc_target), 64'hC00);
    next_cyc();

    // Kill in WAIT: id_valid drops while the hazard persists
    drv_id(1'b1, BEQ, 5'd5, 5'd6, 32'h3, 32'h3, 32'hD00);
    drv_haz(1'b1, 1'b0, 5'd5, 1'b0, 5'd0);
    outs("kill_stall", 1'b1, 1'b0, 1'b0);
    next_cyc();
    id_valid = 1'b0;
    outs("kill_wait", 1'b0, 1'b0, 1'b0);
    next_cyc();
    nop();
    outs("kill_after", 1'b0, 1'b0, 1'b0);
    chk("kill_after.pc_target", 64'(pc_target), 64'hC00);
    next_cyc();

    // Undefined opcode with a matching EX producer
    drv_id(1'b1, 6'h3F, 5'd5, 5'd6, 32'h3, 32'h3, 32'hE00);
    drv_haz(1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    outs("undef", 1'b0, 1'b0, 1'b0);
    next_cyc();
    nop();
    outs("undef_next", 1'b0, 1'b0, 1'b0);
    next_cyc();

    // Reset asserted during REDIRECT
    drv_id(1'b1, BEQ, 5'd1, 5'd2, 32'hAA, 32'hAA, 32'hF00);
    next_cyc();
    nop();
    outs("rst_redir", 1'b0, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async.pc_sel", 64'(pc_sel), 64'h0);
    chk("rst_async.flush", 64'(flush_ifid), 64'h0);
    chk("rst_async.pc_target", 64'(pc_target), 64'h0);
    #1 rst_n = 1'b1;
    next_cyc();
    outs("rst_after", 1'b0, 1'b0, 1'b0);
    next_cyc();

`ifdef BRANCH_STATS_EN
    // Three branches: BEQ taken with 2 load stalls, BNE taken with 1 ALU stall, BNE not taken
    drv_id(1'b1, BEQ, 5'd3, 5'd4, 32'h1, 32'h1, 32'h10);
    drv_haz(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    next_cyc();
    drv_haz(1'b0, 1'b0, 5'd0, 1'b1, 5'd3);
    next_cyc();
    drv_haz(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    next_cyc();
    nop();
    next_cyc();
    drv_id(1'b1, BNE, 5'd7, 5'd8, 32'h1, 32'h2, 32'h20);
    drv_haz(1'b1, 1'b0, 5'd7, 1'b0, 5'd0);
    next_cyc();
    drv_haz(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    next_cyc();
    nop();
    next_cyc();
    drv_id(1'b1, BNE, 5'd1, 5'd2, 32'h9, 32'h9, 32'h30);
    next_cyc();
    nop();
    @(negedge clk);
    chk("stat.branches", 64'(stat_branches), 64'd3);
    chk("stat.taken", 64'(stat_taken), 64'd2);
    chk("stat.stall_cyc", 64'(stat_stall_cyc), 64'd3);
    next_cyc();
    // Two more taken branches carry stat_taken through all-ones and back to zero
    drv_id(1'b1, BEQ, 5'd1, 5'd2, 32'h4, 32'h4, 32'h40);
    next_cyc();
    nop();
    @(negedge clk);
    chk("stat.taken_ones", 64'(stat_taken), 64'd3);
    chk("stat.branches_wrap", 64'(stat_branches), 64'd0);
    next_cyc();
    drv_id(1'b1, BEQ, 5'd1, 5'd2, 32'h4, 32'h4, 32'h50);
    next_cyc();
    nop();
    @(negedge clk);
    chk("stat.taken_wrap", 64'(stat_taken), 64'd0);
    next_cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
